// File: rtl/hazard_unit_if.sv
// ID-side bundle between the decode stage and the hazard unit.
// The hazard unit returns stall/forward controls on the same bundle.
interface hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_is_store;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;
  logic             mem_busy;
  logic             stall;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic [1:0]       forward_mem;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt,
    output id_is_store, id_rd, id_regwrite,
    output id_memread, flush, mem_busy,
    input  stall, forward_a, forward_b,
    input  forward_mem, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt,
    input  id_is_store, id_rd, id_regwrite,
    input  id_memread, flush, mem_busy,
    output stall, forward_a, forward_b,
    output forward_mem, stall_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use stall detection and registered forwarding selects
// for the 5-stage core, sampled alongside the ID stage.
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_unit_if.slave  bus
);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic             is_store;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rt;
  } slot_t;

  // The WB slot never feeds a select, so only EX and MEM are held.
  slot_t            r_ex;
  slot_t            r_mem;
  logic [1:0]       r_fa;
  logic [1:0]       r_fb;
  logic [1:0]       r_fm;
  logic [CNT_W-1:0] r_cnt;

  slot_t      w_id;
  logic       w_lu;
  logic       w_bubble;
  logic       w_no_fwd;
  logic [1:0] w_fa;
  logic [1:0] w_fb;
  logic [1:0] w_fm;

  function automatic logic hit(
    input slot_t s,
    input logic [REG_W-1:0] r
  );
    return s.valid && s.regwrite &&
           (s.rd == r) && (r != '0);
  endfunction

  function automatic logic [1:0] sel(
    input slot_t ex,
    input slot_t mem,
    input logic [REG_W-1:0] r
  );
    if (hit(ex, r) && !ex.memread)
      return 2'b10;
    else if (hit(mem, r))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    w_id = '{
      valid:    bus.id_valid,
      regwrite: bus.id_regwrite,
      memread:  bus.id_memread,
      is_store: bus.id_is_store,
      rd:       bus.id_rd,
      rt:       bus.id_rt
    };
  end

  // Store data from a load in EX is picked up later in MEM.
  assign w_lu = bus.id_valid && r_ex.memread &&
                (hit(r_ex, bus.id_rs) ||
                 (bus.id_uses_rt && !bus.id_is_store &&
                  hit(r_ex, bus.id_rt)));

  assign w_bubble = bus.flush || w_lu;
  assign w_no_fwd = w_bubble || !bus.id_valid;

  always_comb begin
    w_fa = 2'b00;
    w_fb = 2'b00;
    w_fm = 2'b00;
    if (!w_no_fwd) begin
      w_fa = sel(r_ex, r_mem, bus.id_rs);
      w_fb = sel(r_ex, r_mem, bus.id_rt);
    end
    if (r_ex.valid && r_ex.is_store &&
        hit(r_mem, r_ex.rt))
      w_fm = r_mem.memread ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_fa  <= 2'b00;
      r_fb  <= 2'b00;
      r_fm  <= 2'b00;
      r_cnt <= '0;
    end else if (!bus.mem_busy) begin
      r_ex  <= w_bubble ? '0 : w_id;
      r_mem <= r_ex;
      r_fa  <= w_fa;
      r_fb  <= w_fb;
      r_fm  <= w_fm;
      if (w_lu && !bus.flush && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.stall       = w_lu && !bus.mem_busy;
  assign bus.forward_a   = r_fa;
  assign bus.forward_b   = r_fb;
  assign bus.forward_mem = r_fm;
  assign bus.stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios plus
// random instruction streams against an instruction-level model.
module tb_hazard_unit;

  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_W(RW), .CNT_W(CW)) bus();

  hazard_unit #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       v;
    logic       we;
    logic       ld;
    logic       st;
    logic       urt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ins_t;

  // pipe[0] = instruction in EX, pipe[1] = instruction in MEM
  ins_t pipe[2];
  int   m_fa, m_fb, m_fm, m_cnt;
  int   n_run = 0;
  int   n_fail = 0;
  logic last_stall;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(
    input logic v, input logic we, input logic ld,
    input logic st, input logic urt,
    input int rs, input int rt, input int rd
  );
    ins_t i;
    i.v = v; i.we = we; i.ld = ld; i.st = st; i.urt = urt;
    i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    return i;
  endfunction

  function automatic ins_t alu(input int rd, input int rs, input int rt, input logic urt);
    return mk(1, 1, 0, 0, urt, rs, rt, rd);
  endfunction
  function automatic ins_t lw(input int rd, input int rs);
    return mk(1, 1, 1, 0, 0, rs, 0, rd);
  endfunction
  function automatic ins_t sw(input int rs, input int rt);
    return mk(1, 0, 0, 1, 0, rs, rt, 0);
  endfunction
  function automatic ins_t nop();
    return mk(1, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic ins_t none();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bit writes(input ins_t p, input logic [4:0] r);
    return p.v && p.we && r != 0 && p.rd == r;
  endfunction

  function automatic int pick(input logic [4:0] r);
    if (writes(pipe[0], r) && !pipe[0].ld) return 2;
    if (writes(pipe[1], r)) return 1;
    return 0;
  endfunction

  function automatic bit m_lu(input ins_t i);
    return i.v && pipe[0].ld &&
           (writes(pipe[0], i.rs) ||
            (i.urt && !i.st && writes(pipe[0], i.rt)));
  endfunction

  task automatic m_reset();
    pipe[0] = none();
    pipe[1] = none();
    m_fa = 0; m_fb = 0; m_fm = 0; m_cnt = 0;
  endtask

  task automatic m_edge(input ins_t i, input bit fl, input bit bz);
    bit lu;
    if (bz) return;
    lu = m_lu(i);
    if (fl || lu || !i.v) begin
      m_fa = 0; m_fb = 0;
    end else begin
      m_fa = pick(i.rs); m_fb = pick(i.rt);
    end
    m_fm = 0;
    if (pipe[0].v && pipe[0].st && writes(pipe[1], pipe[0].rt))
      m_fm = pipe[1].ld ? 2 : 1;
    if (lu && !fl && m_cnt < CMAX) m_cnt++;
    pipe[1] = pipe[0];
    pipe[0] = (fl || lu) ? none() : i;
  endtask

  task automatic drive(input ins_t i, input bit fl, input bit bz);
    bus.id_valid    = i.v;
    bus.id_rs       = i.rs;
    bus.id_rt       = i.rt;
    bus.id_uses_rt  = i.urt;
    bus.id_is_store = i.st;
    bus.id_rd       = i.rd;
    bus.id_regwrite = i.we;
    bus.id_memread  = i.ld;
    bus.flush       = fl;
    bus.mem_busy    = bz;
  endtask

  task automatic step(input ins_t i, input bit fl, input bit bz);
    @(negedge clk);
    drive(i, fl, bz);
    #1;
    last_stall = bus.stall;
    chk("stall", int'(bus.stall), int'(m_lu(i) && !bz));
    @(posedge clk);
    m_edge(i, fl, bz);
    #1;
    chk("fwd_a", int'(bus.forward_a), m_fa);
    chk("fwd_b", int'(bus.forward_b), m_fb);
    chk("fwd_mem", int'(bus.forward_mem), m_fm);
    chk("count", int'(bus.stall_count), m_cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, int'(bus.stall), 0);
    chk({tag, "_fa"}, int'(bus.forward_a), 0);
    chk({tag, "_fb"}, int'(bus.forward_b), 0);
    chk({tag, "_fm"}, int'(bus.forward_mem), 0);
    chk({tag, "_cnt"}, int'(bus.stall_count), 0);
  endtask

  initial begin
    ins_t cur;
    bit   fl, bz;
    m_reset();
    drive(none(), 0, 0);
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // back-to-back ALU dependency
    step(alu(3, 1, 2, 1), 0, 0);
    step(alu(4, 3, 0, 0), 0, 0);
    chk("b2b_fa", int'(bus.forward_a), 2);
    chk("b2b_stall", int'(last_stall), 0);

    // one-instruction gap, then the same with $0
    step(alu(3, 1, 2, 1), 0, 0);
    step(nop(), 0, 0);
    step(alu(6, 1, 3, 1), 0, 0);
    chk("gap_fb", int'(bus.forward_b), 1);
    step(alu(0, 1, 2, 1), 0, 0);
    step(nop(), 0, 0);
    step(alu(6, 1, 0, 1), 0, 0);
    chk("gap_r0_fb", int'(bus.forward_b), 0);

    // load-use: one stall, then MEM/WB forward
    step(lw(5, 1), 0, 0);
    step(alu(6, 5, 2, 1), 0, 0);
    chk("lu_stall", int'(last_stall), 1);
    step(alu(6, 5, 2, 1), 0, 0);
    chk("lu_stall_end", int'(last_stall), 0);
    chk("lu_fa", int'(bus.forward_a), 1);
    chk("lu_cnt", int'(bus.stall_count), 1);

    // load-to-store: no stall, WB load data into store
    step(lw(5, 1), 0, 0);
    step(sw(2, 5), 0, 0);
    chk("ldst_stall", int'(last_stall), 0);
    step(nop(), 0, 0);
    chk("ldst_fm", int'(bus.forward_mem), 2);

    // double match: nearest producer wins
    step(alu(7, 1, 2, 1), 0, 0);
    step(alu(7, 2, 1, 1), 0, 0);
    step(alu(8, 7, 1, 1), 0, 0);
    chk("dbl_fa", int'(bus.forward_a), 2);

    // mem_busy across a load-use hazard
    step(lw(5, 1), 0, 0);
    repeat (3) step(alu(6, 5, 2, 1), 0, 1);
    chk("busy_stall", int'(last_stall), 0);
    step(alu(6, 5, 2, 1), 0, 0);
    chk("busy_rel_stall", int'(last_stall), 1);
    step(alu(6, 5, 2, 1), 0, 0);

    // reset in the middle of a stall
    step(lw(5, 1), 0, 0);
    @(negedge clk);
    drive(alu(6, 5, 2, 1), 0, 0);
    #1;
    chk("pre_rst_stall", int'(bus.stall), 1);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // drive the counter into saturation
    for (int k = 0; k < CMAX + 3; k++) begin
      step(lw(5, 1), 0, 0);
      step(alu(6, 5, 2, 1), 0, 0);
      step(alu(6, 5, 2, 1), 0, 0);
    end
    chk("sat_cnt", int'(bus.stall_count), CMAX);

    // random streams over a small register set
    cur = nop();
    last_stall = 0;
    bz = 0;
    for (int n = 0; n < 600; n++) begin
      if (!(last_stall || bz)) begin
        case ($urandom_range(0, 3))
          0: cur = alu($urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)));
          1: cur = lw($urandom_range(0, 3), $urandom_range(0, 3));
          2: cur = sw($urandom_range(0, 3), $urandom_range(0, 3));
          default: cur = nop();
        endcase
        cur.v = ($urandom_range(0, 7) != 0);
      end
      fl = ($urandom_range(0, 9) == 0);
      bz = ($urandom_range(0, 6) == 0);
      step(cur, fl, bz);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
